// File: rtl/axil_cmd_pkg.sv
// Shared definitions for the AXI4-Lite command master: FSM states,
// response codes and default interface widths.
package axil_cmd_pkg;

    localparam int AXIL_ADDR_W = 4;
    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_CNT_W  = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

endpackage

// File: rtl/axil_cmd_master.sv
// Turns one command-port request into a single AXI4-Lite read or write; 3-cycle min accept-to-response.
// One transaction in flight: cmd_ready only in IDLE, response held until rsp_ready, AXI VALIDs never withdrawn.
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = AXIL_ADDR_W,
    parameter int C_M_AXI_DATA_WIDTH = AXIL_DATA_W,
    parameter int C_CNT_WIDTH        = AXIL_CNT_W
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_wr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_wr,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,

    output logic                            err_sticky,
    output logic [C_CNT_WIDTH-1:0]          txn_cnt
);

    // Word-aligned addressing: byte-offset bits are dropped when the command is latched.
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~C_M_AXI_ADDR_WIDTH'(3);

    state_t                          state;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic                            aw_pend_nxt;
    logic                            w_pend_nxt;

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    // AW and W retire independently; each stays pending until its own handshake.
    assign aw_pend_nxt = M_AXI_AWVALID & ~M_AXI_AWREADY;
    assign w_pend_nxt  = M_AXI_WVALID  & ~M_AXI_WREADY;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            cmd_ready     <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_wr        <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            txn_cnt       <= '0;
            err_sticky    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr_q    <= cmd_addr & ADDR_MASK;
                        wdata_q   <= cmd_wdata;
                        rsp_wr    <= cmd_wr;
                        if (cmd_wr) begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    M_AXI_AWVALID <= aw_pend_nxt;
                    M_AXI_WVALID  <= w_pend_nxt;
                    if (!aw_pend_nxt && !w_pend_nxt) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID && M_AXI_BREADY) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        if (M_AXI_BRESP != RESP_OKAY)
                            err_sticky <= 1'b1;
                        state <= RSP;
                    end
                end
                RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID && M_AXI_RREADY) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_valid    <= 1'b1;
                        if (M_AXI_RRESP != RESP_OKAY)
                            err_sticky <= 1'b1;
                        state <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_cnt   <= txn_cnt + C_CNT_WIDTH'(1);
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Randomized bench for axil_cmd_master: a 4-register AXI4-Lite slave with programmable
// ready/response delays and error injection, checked against a register-array reference model.
module tb_axil_cmd_master;
    import axil_cmd_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int CW = 16;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_wr;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] M_AXI_AWADDR;
    logic [2:0]    M_AXI_AWPROT;
    logic          M_AXI_AWVALID;
    logic          M_AXI_AWREADY = 1'b0;
    logic [DW-1:0] M_AXI_WDATA;
    logic [3:0]    M_AXI_WSTRB;
    logic          M_AXI_WVALID;
    logic          M_AXI_WREADY = 1'b0;
    logic [1:0]    M_AXI_BRESP = 2'b00;
    logic          M_AXI_BVALID = 1'b0;
    logic          M_AXI_BREADY;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [2:0]    M_AXI_ARPROT;
    logic          M_AXI_ARVALID;
    logic          M_AXI_ARREADY = 1'b0;
    logic [DW-1:0] M_AXI_RDATA = '0;
    logic [1:0]    M_AXI_RRESP = 2'b00;
    logic          M_AXI_RVALID = 1'b0;
    logic          M_AXI_RREADY;
    logic          err_sticky;
    logic [CW-1:0] txn_cnt;

    axil_cmd_master #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_CNT_WIDTH(CW)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .err_sticky(err_sticky), .txn_cnt(txn_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Slave configuration, written only by the stimulus process.
    int s_aw_dly = 0, s_w_dly = 0, s_b_dly = 0, s_ar_dly = 0, s_r_dly = 0;
    bit s_err = 1'b0;

    // Slave state, owned by the slave process.
    logic [DW-1:0] s_mem [4];
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata;
    bit aw_got, w_got, b_issued, ar_got, r_issued, bready_q, rready_q;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;

    // Slave drives on the falling edge; a ready/valid it drove last falling edge
    // tells it whether the rising edge in between completed a handshake.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
            M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
            M_AXI_BRESP = 2'b00; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
            aw_got = 0; w_got = 0; b_issued = 0; ar_got = 0; r_issued = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            bready_q = 0; rready_q = 0;
            for (int i = 0; i < 4; i++) s_mem[i] = '0;
        end else begin
            if (M_AXI_AWREADY) begin aw_got = 1; M_AXI_AWREADY = 1'b0; end
            if (M_AXI_WREADY)  begin w_got = 1;  M_AXI_WREADY = 1'b0;  end
            if (M_AXI_ARREADY) begin ar_got = 1; M_AXI_ARREADY = 1'b0; end
            if (M_AXI_BVALID && bready_q) begin
                M_AXI_BVALID = 1'b0;
                aw_got = 0; w_got = 0; b_issued = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
            end
            if (M_AXI_RVALID && rready_q) begin
                M_AXI_RVALID = 1'b0;
                ar_got = 0; r_issued = 0; ar_wait = 0; r_wait = 0;
            end
            if (M_AXI_AWVALID && !aw_got) begin
                if (aw_wait >= s_aw_dly) begin M_AXI_AWREADY = 1'b1; s_awaddr = M_AXI_AWADDR; end
                else aw_wait++;
            end
            if (M_AXI_WVALID && !w_got) begin
                if (w_wait >= s_w_dly) begin M_AXI_WREADY = 1'b1; s_wdata = M_AXI_WDATA; end
                else w_wait++;
            end
            if (aw_got && w_got && !b_issued) begin
                if (b_wait >= s_b_dly) begin
                    M_AXI_BVALID = 1'b1;
                    M_AXI_BRESP  = s_err ? RESP_SLVERR : RESP_OKAY;
                    if (!s_err) s_mem[s_awaddr[3:2]] = s_wdata;
                    b_issued = 1;
                end else b_wait++;
            end
            if (M_AXI_ARVALID && !ar_got) begin
                if (ar_wait >= s_ar_dly) begin M_AXI_ARREADY = 1'b1; s_araddr = M_AXI_ARADDR; end
                else ar_wait++;
            end
            if (ar_got && !r_issued) begin
                if (r_wait >= s_r_dly) begin
                    M_AXI_RVALID = 1'b1;
                    M_AXI_RDATA  = s_mem[s_araddr[3:2]];
                    M_AXI_RRESP  = s_err ? RESP_SLVERR : RESP_OKAY;
                    r_issued = 1;
                end else r_wait++;
            end
            bready_q = M_AXI_BREADY;
            rready_q = M_AXI_RREADY;
        end
    end

    // Protocol monitor: handshake counts and VALID hold/drop violations.
    int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0, proto_bad = 0;
    bit aw_pend, aw_done, w_pend, w_done, ar_pend, ar_done;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_pend = 0; aw_done = 0; w_pend = 0; w_done = 0; ar_pend = 0; ar_done = 0;
        end else begin
            if (aw_pend && !(M_AXI_AWVALID && M_AXI_AWADDR == p_awaddr)) proto_bad++;
            if (w_pend  && !(M_AXI_WVALID  && M_AXI_WDATA  == p_wdata))  proto_bad++;
            if (ar_pend && !(M_AXI_ARVALID && M_AXI_ARADDR == p_araddr)) proto_bad++;
            if (aw_done && M_AXI_AWVALID) proto_bad++;
            if (w_done  && M_AXI_WVALID)  proto_bad++;
            if (ar_done && M_AXI_ARVALID) proto_bad++;
            if (M_AXI_AWPROT != 3'b000 || M_AXI_ARPROT != 3'b000 || M_AXI_WSTRB != 4'hF) proto_bad++;
            aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY; aw_done = M_AXI_AWVALID && M_AXI_AWREADY;
            w_pend  = M_AXI_WVALID  && !M_AXI_WREADY;  w_done  = M_AXI_WVALID  && M_AXI_WREADY;
            ar_pend = M_AXI_ARVALID && !M_AXI_ARREADY; ar_done = M_AXI_ARVALID && M_AXI_ARREADY;
            p_awaddr = M_AXI_AWADDR; p_wdata = M_AXI_WDATA; p_araddr = M_AXI_ARADDR;
            if (aw_done) aw_hs_n++;
            if (w_done)  w_hs_n++;
            if (ar_done) ar_hs_n++;
            if (M_AXI_BVALID && M_AXI_BREADY) b_hs_n++;
            if (M_AXI_RVALID && M_AXI_RREADY) r_hs_n++;
        end
    end

    // Reference model: register contents, completed count, sticky error.
    logic [DW-1:0] ref_mem [4];
    int            exp_cnt = 0;
    bit            exp_err = 0;

    task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int awd, input int wd, input int bd, input bit err, input int stall);
        logic [DW-1:0] exp_rdata, snap;
        logic [1:0]    exp_resp;
        int lat, t;
        int a0, w0, b0, ar0, r0, pb0;
        bit ok;
        logic [19:0] hs, hs_exp;
        s_aw_dly = awd; s_w_dly = wd; s_b_dly = bd; s_ar_dly = awd; s_r_dly = bd; s_err = err;
        exp_rdata = wr ? '0 : ref_mem[addr[3:2]];
        exp_resp  = err ? 2'b10 : 2'b00;
        if (wr && !err) ref_mem[addr[3:2]] = data;
        if (err) exp_err = 1;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        a0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; ar0 = ar_hs_n; r0 = r_hs_n; pb0 = proto_bad;

        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge ACLK); t++; end
        if (!cmd_ready) begin
            check_eq("cmd_ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge ACLK); lat++; end
        if (!rsp_valid) begin
            check_eq("rsp_timeout", 0, 1);
            return;
        end
        if (awd == 0 && wd == 0 && bd == 0) check_eq("latency", lat, 3);
        check_eq("rsp_wr", rsp_wr, wr);
        check_eq("rsp_rdata", rsp_rdata, exp_rdata);
        check_eq("rsp_resp", rsp_resp, exp_resp);
        check_eq("err_sticky", err_sticky, exp_err);
        if (wr) check_eq("awaddr", s_awaddr, addr & 4'hC);
        else    check_eq("araddr", s_araddr, addr & 4'hC);

        snap = rsp_rdata;
        ok = 1;
        repeat (stall) begin
            @(negedge ACLK);
            if (!(rsp_valid && rsp_rdata == snap && rsp_resp == exp_resp && rsp_wr == wr && !cmd_ready &&
                  !M_AXI_AWVALID && !M_AXI_WVALID && !M_AXI_ARVALID && !M_AXI_BREADY && !M_AXI_RREADY))
                ok = 0;
        end
        if (stall > 0) check_eq("rsp_hold", ok, 1);

        rsp_ready = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        rsp_ready = 1'b0;
        check_eq("rsp_valid_drop", rsp_valid, 0);
        check_eq("cmd_ready_again", cmd_ready, 1);
        check_eq("txn_cnt", txn_cnt, exp_cnt);
        hs = {4'(aw_hs_n - a0), 4'(w_hs_n - w0), 4'(b_hs_n - b0), 4'(ar_hs_n - ar0), 4'(r_hs_n - r0)};
        hs_exp = wr ? 20'h11100 : 20'h00011;
        check_eq("hs_counts", hs, hs_exp);
        check_eq("proto", proto_bad - pb0, 0);
    endtask

    initial begin
        logic [6:0] outs;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;

        repeat (3) @(negedge ACLK);
        outs = {cmd_ready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid};
        check_eq("reset_ctrl", outs, 0);
        check_eq("reset_status", {err_sticky, txn_cnt, rsp_rdata, rsp_resp}, 0);
        check_eq("reset_addr", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA}, 0);
        #2 ARESETN = 1'b1;
        #1 check_eq("cmd_ready_in_rst_exit", cmd_ready, 0);
        @(negedge ACLK);
        check_eq("cmd_ready_rise", cmd_ready, 1);

        // Fill the four registers, then read them back with a zero-wait slave.
        for (int i = 0; i < 4; i++) do_txn(1, 4'(i * 4), 32'(i + 1), 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_txn(0, 4'(i * 4), 32'h0, 0, 0, 0, 0, 0);
        check_eq("cnt_after_8", txn_cnt, 8);

        // AW and W accepted in either order with a 3-cycle gap.
        do_txn(1, 4'h4, 32'hA5A5_0001, 0, 3, 0, 0, 0);
        do_txn(1, 4'h8, 32'hA5A5_0002, 3, 0, 1, 0, 0);
        // Byte-offset bits are dropped from the address.
        do_txn(1, 4'h7, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        do_txn(0, 4'h5, 32'h0, 0, 0, 0, 0, 0);
        // Response back-pressure.
        do_txn(0, 4'h4, 32'h0, 1, 0, 2, 0, 10);
        // Error response then clean traffic; the error bit must stay set.
        do_txn(1, 4'hC, 32'h1234_5678, 0, 0, 0, 1, 0);
        do_txn(0, 4'hC, 32'h0, 0, 0, 0, 0, 0);
        do_txn(1, 4'h0, 32'h0BAD_F00D, 0, 0, 0, 0, 2);

        // Reset while ARVALID waits for ARREADY.
        s_ar_dly = 30; s_err = 0;
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'h4;
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        repeat (2) @(negedge ACLK);
        check_eq("ar_waiting", M_AXI_ARVALID, 1);
        #2 ARESETN = 1'b0;
        #1;
        outs = {cmd_ready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid};
        check_eq("midrst_ctrl", outs, 0);
        check_eq("midrst_status", {err_sticky, txn_cnt, rsp_rdata, M_AXI_ARADDR}, 0);
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        exp_cnt = 0; exp_err = 0;
        repeat (2) @(negedge ACLK);
        #2 ARESETN = 1'b1;
        @(negedge ACLK);
        check_eq("midrst_cmd_ready", cmd_ready, 1);
        check_eq("midrst_no_rsp", rsp_valid, 0);
        check_eq("midrst_txn_cnt", txn_cnt, 0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            bit            wr, err;
            logic [AW-1:0] addr;
            int            awd, wd, bd, stall;
            wr    = 1'($urandom_range(0, 1));
            addr  = 4'($urandom_range(0, 15));
            err   = ($urandom_range(0, 7) == 0);
            awd   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 3);
            wd    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 3);
            bd    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 3);
            stall = $urandom_range(0, 3);
            do_txn(wr, addr, $urandom, awd, wd, bd, err, stall);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 4, AXI4-Lite address width (4 x 32-bit decoder registers).
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 supported.
REQ-003 SHALL have parameter C_CNT_WIDTH, default 16, width of the completed-transaction counter.
REQ-004 SHALL have ports ACLK in 1, sole clock; ARESETN in 1, asynchronous active-low reset.
REQ-005 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_wr in 1 (1=write, 0=read), cmd_addr in ADDR_WIDTH, cmd_wdata in DATA_WIDTH: command port.
REQ-006 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_wr out 1, rsp_rdata out DATA_WIDTH, rsp_resp out 2: response port.
REQ-007 SHALL have M_AXI_AWADDR out ADDR_WIDTH, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
REQ-008 SHALL have M_AXI_WDATA out DATA_WIDTH, M_AXI_WSTRB out DATA_WIDTH/8, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-009 SHALL have M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
REQ-010 SHALL have M_AXI_ARADDR out ADDR_WIDTH, M_AXI_ARPROT out 3, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1, M_AXI_RDATA in DATA_WIDTH, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.
REQ-011 SHALL have status outputs err_sticky out 1 (any non-OKAY response seen) and txn_cnt out C_CNT_WIDTH (completed transactions).

Function
REQ-012 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-013 SHALL assert cmd_ready only in IDLE; on cmd_valid&cmd_ready latch command and go to WR_REQ (cmd_wr=1) or RD_REQ (cmd_wr=0).
REQ-014 SHALL drive AWADDR/ARADDR = latched cmd_addr with bits [1:0] forced to 0; AWPROT=ARPROT=3'b000; WSTRB all ones.
REQ-015 SHALL assert AWVALID and WVALID together in the cycle after command acceptance; each deasserts in the cycle after its own handshake, independently.
REQ-016 SHALL move WR_REQ -> WR_RESP once both AW and W handshakes have occurred (same or different cycles, either order).
REQ-017 SHALL assert BREADY only in WR_RESP; on BVALID&BREADY capture BRESP, go to RSP.
REQ-018 SHALL assert ARVALID in RD_REQ (cycle after acceptance) until ARREADY, then go to RD_DATA.
REQ-019 SHALL assert RREADY only in RD_DATA; on RVALID&RREADY capture RDATA/RRESP, go to RSP.
REQ-020 SHALL hold rsp_valid=1 in RSP with stable rsp_* until rsp_ready; then return to IDLE; rsp_rdata=0 for writes.
REQ-021 SHALL keep every VALID asserted, with stable payload, until its handshake (no withdrawal).
REQ-022 SHALL increment txn_cnt by 1 on each rsp handshake, wrapping from all-ones to 0.
REQ-023 SHALL set err_sticky when captured BRESP or RRESP != 2'b00; cleared only by reset.
REQ-024 Minimum latency: command accept cycle N, AW/W valid N+1, zero-wait slave BVALID N+2, rsp_valid N+3; next cmd_ready earliest cycle after rsp handshake.
REQ-025 SHALL ignore BVALID/RVALID outside WR_RESP/RD_DATA (not captured, no state change).

Reset
REQ-026 While ARESETN=0: state IDLE; all VALID/READY outputs 0 except cmd_ready=0; addresses, data, rsp_*, txn_cnt, err_sticky = 0.
REQ-027 cmd_ready SHALL rise in the first ACLK cycle after ARESETN deasserts.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no response issued; slave is reset by same ARESETN.

Structure
REQ-029 SHALL place FSM state enum, AXI response constants (OKAY=00, SLVERR=10) and default widths in shared package axil_cmd_pkg.
REQ-030 SHALL be a single module; no sub-module required.

Verification
REQ-031 Writes 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC into decoder slave then reads same addresses -> rsp_rdata 0x1..0x4, rsp_resp 00, txn_cnt=8, err_sticky=0.
REQ-032 Slave AWREADY 3 cycles before WREADY, then reversed order -> each VALID drops independently, single B accepted, one response per write.
REQ-033 Slave returns BRESP=2'b10 on one write -> rsp_resp=10, err_sticky=1 and stays 1 through subsequent OKAY transactions.
REQ-034 rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_* stable, cmd_ready 0, no AXI activity until release.
REQ-035 ARESETN pulsed low while ARVALID=1 awaiting ARREADY -> all outputs 0 immediately, cmd_ready=1 cycle after release, txn_cnt=0.
REQ-036 cmd_addr=0x7 write -> AWADDR=0x4.
